// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code sequencer.
// Event layout, FSM state encoding, prefix/status bytes and byte classifiers.
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_E0    = 3'd1,
    S_F0    = 3'd2,
    S_E0F0  = 3'd3,
    S_PAUSE = 3'd4
  } ps2_seq_state_t;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_ST_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ST_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ST_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ST_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ST_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ST_ERR_HI = 8'hFF;

  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  // Bytes following E1 before the pause event is complete.
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_ST_BAT_OK) || (b == PS2_ST_ACK)    || (b == PS2_ST_ECHO) ||
           (b == PS2_ST_RESEND) || (b == PS2_ST_ERR_LO) || (b == PS2_ST_ERR_HI);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO of key events; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     i_push,
  input  ps2_evt_t                 i_din,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output ps2_evt_t                 o_head
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t            r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Decodes set-2 prefix sequences (E0/F0/E1) from received PS/2 bytes into key
// events, with inter-byte timeout, error abort and sticky overflow flag.
module ps2_scancode_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk_50MHz,
  input  logic                         clr,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_err,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_brk,
  output logic                         seq_err,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  ps2_seq_state_t r_state, w_state_nxt;
  logic [2:0]     r_skip, w_skip_nxt;
  logic [TW-1:0]  r_timer;
  logic           r_seq_err;
  logic           r_overflow;
  logic           w_timeout;
  logic           w_abort;
  logic           w_push;
  ps2_evt_t       w_evt;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  ps2_evt_t       w_head;

  assign w_timeout = (r_state != IDLE) && !rx_valid && !rx_err && (r_timer == TMAX);
  assign w_abort   = rx_err || w_timeout;

  always_ff @(posedge clk_50MHz) begin
    if (clr) begin
      r_state <= IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_byte == PS2_PFX_EXT)        w_state_nxt = S_E0;
          else if (rx_byte == PS2_PFX_BRK)   w_state_nxt = S_F0;
          else if (rx_byte == PS2_PFX_PAUSE) begin
            w_state_nxt = S_PAUSE;
            w_skip_nxt  = PS2_PAUSE_SKIP;
          end
        end
        S_E0: begin
          if (rx_byte == PS2_PFX_BRK)      w_state_nxt = S_E0F0;
          else if (rx_byte != PS2_PFX_EXT) w_state_nxt = IDLE;
        end
        S_PAUSE: begin
          if (r_skip <= 3'd1) w_state_nxt = IDLE;
          else                w_skip_nxt  = r_skip - 3'd1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Event emission happens on the edge that consumes the sequence's last byte.
  always_comb begin
    w_push = 1'b0;
    w_evt  = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
    if (rx_valid && !rx_err) begin
      case (r_state)
        IDLE: w_push = (rx_byte != PS2_PFX_EXT) && (rx_byte != PS2_PFX_BRK) &&
                       (rx_byte != PS2_PFX_PAUSE) && !is_status_byte(rx_byte);
        S_E0: begin
          w_evt.ext = 1'b1;
          w_push    = (rx_byte != PS2_PFX_BRK) && (rx_byte != PS2_PFX_EXT) &&
                      !is_fake_shift(rx_byte);
        end
        S_F0: begin
          w_evt.brk = 1'b1;
          w_push    = 1'b1;
        end
        S_E0F0: begin
          w_evt.ext = 1'b1;
          w_evt.brk = 1'b1;
          w_push    = !is_fake_shift(rx_byte);
        end
        S_PAUSE: begin
          w_evt.ext  = 1'b1;
          w_evt.code = PS2_PFX_PAUSE;
          w_push     = (r_skip <= 3'd1);
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (clr || rx_valid || rx_err || (r_state == IDLE) || w_timeout) r_timer <= '0;
    else                                                             r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (clr) begin
      r_seq_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_seq_err  <= w_abort;
      r_overflow <= r_overflow | (w_push && w_full && !w_pop);
    end
  end

  assign w_pop = !w_empty && evt_ready;

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_50MHz),
    .clr     (clr),
    .i_push  (w_push),
    .i_din   (w_evt),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count),
    .o_head  (w_head)
  );

  assign evt_valid = !w_empty;
  assign evt_code  = w_empty ? 8'h00 : w_head.code;
  assign evt_ext   = !w_empty && w_head.ext;
  assign evt_brk   = !w_empty && w_head.brk;
  assign seq_err   = r_seq_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for ps2_scancode_sequencer; popped events are logged as
// {ext,brk,code} and compared against hand-computed sequences.
module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic       clk_50MHz = 1'b0;
  logic       clr       = 1'b1;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_byte   = 8'h00;
  logic       rx_err    = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       seq_err;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] popped [$];
  int         n_seq_err = 0;
  int         q_base;
  int         err_base;

  ps2_scancode_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50MHz  (clk_50MHz),
    .clr        (clr),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_err     (rx_err),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_brk    (evt_brk),
    .seq_err    (seq_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk_50MHz) begin
    if (evt_valid && evt_ready) popped.push_back({evt_ext, evt_brk, evt_code});
    if (seq_err) n_seq_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int idx, input logic [9:0] exp);
    logic [9:0] got;
    got = ((q_base + idx) < popped.size()) ? popped[q_base + idx] : 10'h3FF;
    chk(tag, {22'd0, got}, {22'd0, exp});
  endtask

  task automatic mark();
    q_base   = popped.size();
    err_base = n_seq_err;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk_50MHz); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk_50MHz); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    cycles(3);
    @(negedge clk_50MHz);
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ovf",   {31'd0, overflow}, 0);
    chk("rst_err",   {31'd0, seq_err}, 0);
    chk("rst_code",  {24'd0, evt_code}, 0);
    clr = 1'b0;
    evt_ready = 1'b1;

    // Plain make, then break; evt_valid must be up one cycle after the push edge.
    mark();
    send(8'h1C);
    @(negedge clk_50MHz);
    chk("lat_valid", {31'd0, evt_valid}, 1);
    chk("lat_code",  {24'd0, evt_code}, 32'h1C);
    send(8'hF0); send(8'h1C);
    cycles(3);
    chk("mk_brk_n", popped.size() - q_base, 2);
    chk_evt("make_1c", 0, 10'h01C);
    chk_evt("brk_1c",  1, 10'h11C);
    chk("mk_brk_err", n_seq_err - err_base, 0);

    // Extended make/break plus an ignored status byte.
    mark();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA);
    cycles(3);
    chk("ext_n", popped.size() - q_base, 2);
    chk_evt("ext_make", 0, 10'h275);
    chk_evt("ext_brk",  1, 10'h375);

    // Pause sequence and fake-shift suppression.
    mark();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    cycles(3);
    chk("pause_n", popped.size() - q_base, 1);
    chk_evt("pause_evt", 0, 10'h2E1);
    mark();
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    cycles(3);
    chk("fake_n", popped.size() - q_base, 1);
    chk_evt("fake_evt", 0, 10'h27C);

    // Timeout after a lone E0.
    mark();
    send(8'hE0);
    cycles(TMO - 20);
    chk("tmo_early", n_seq_err - err_base, 0);
    cycles(40);
    chk("tmo_err", n_seq_err - err_base, 1);
    send(8'h1C);
    cycles(3);
    chk("tmo_n", popped.size() - q_base, 1);
    chk_evt("tmo_evt", 0, 10'h01C);
    chk("tmo_err2", n_seq_err - err_base, 1);

    // rx_err after F0, then rx_err colliding with a valid byte.
    mark();
    send(8'hF0);
    @(posedge clk_50MHz); #1 rx_err = 1'b1;
    @(posedge clk_50MHz); #1 rx_err = 1'b0;
    cycles(3);
    chk("rxerr_err", n_seq_err - err_base, 1);
    chk("rxerr_n", popped.size() - q_base, 0);
    send(8'hF0);
    @(posedge clk_50MHz); #1;
    rx_err = 1'b1; rx_valid = 1'b1; rx_byte = 8'h1C;
    @(posedge clk_50MHz); #1;
    rx_err = 1'b0; rx_valid = 1'b0;
    send(8'h1C);
    cycles(3);
    chk("collide_err", n_seq_err - err_base, 2);
    chk("collide_n", popped.size() - q_base, 1);
    chk_evt("collide_evt", 0, 10'h01C);

    // Overflow with six makes and no consumer.
    mark();
    evt_ready = 1'b0;
    send(8'h15); send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    @(negedge clk_50MHz);
    chk("ovf_count", {29'd0, fifo_count}, 4);
    chk("ovf_flag",  {31'd0, overflow}, 1);
    chk("ovf_head",  {24'd0, evt_code}, 32'h15);
    chk("ovf_valid", {31'd0, evt_valid}, 1);
    // Push into a full FIFO with a simultaneous pop keeps count at 4.
    @(posedge clk_50MHz); #1;
    rx_valid = 1'b1; rx_byte = 8'h36; evt_ready = 1'b1;
    @(posedge clk_50MHz); #1;
    rx_valid = 1'b0; evt_ready = 1'b0;
    @(negedge clk_50MHz);
    chk("fullpp_count", {29'd0, fifo_count}, 4);
    chk("fullpp_head",  {24'd0, evt_code}, 32'h16);
    evt_ready = 1'b1;
    cycles(8);
    chk("drain_n", popped.size() - q_base, 5);
    chk_evt("drain0", 0, 10'h015);
    chk_evt("drain1", 1, 10'h016);
    chk_evt("drain2", 2, 10'h01E);
    chk_evt("drain3", 3, 10'h026);
    chk_evt("drain4", 4, 10'h036);
    chk("drain_count", {29'd0, fifo_count}, 0);
    chk("ovf_sticky",  {31'd0, overflow}, 1);

    // Reset mid-sequence discards the partial E0.
    mark();
    send(8'hE0);
    @(posedge clk_50MHz); #1 clr = 1'b1;
    @(posedge clk_50MHz); #1 clr = 1'b0;
    @(negedge clk_50MHz);
    chk("clr_ovf",   {31'd0, overflow}, 0);
    chk("clr_count", {29'd0, fifo_count}, 0);
    send(8'h75);
    cycles(3);
    chk("clr_n", popped.size() - q_base, 1);
    chk_evt("clr_evt", 0, 10'h075);
    chk("clr_ovf2", {31'd0, overflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
